// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive path: divider taps, capture
// timing and controller state encoding.
package i2s_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int CNT_W        = 9;
  localparam int SLOT_W       = 5;
  localparam int DISC_W       = 4;

  localparam int MCLK_BIT = 1;
  localparam int SCK_BIT  = 2;
  localparam int LRCK_BIT = 8;

  localparam logic [2:0]       CAPTURE_PHASE  = 3'b110;
  localparam logic [CNT_W-1:0] FRAME_DONE_CNT = 9'h186;

  localparam logic [SLOT_W-1:0] FIRST_DATA_SLOT = 5'd1;
  localparam logic [SLOT_W-1:0] LAST_DATA_SLOT  = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Slot 0 carries the I2S one-bit delay; slots past the sample width are truncated.
  function automatic logic in_data_slot(input logic [SLOT_W-1:0] slot);
    return (slot >= FIRST_DATA_SLOT) && (slot <= LAST_DATA_SLOT);
  endfunction

endpackage

// File: rtl/i2s_rx_ctl_if.sv
// Pin-level bundle between the I2S receive controller and its surroundings
// (ADC serial pins plus the sample interface towards the record logic).
interface i2s_rx_ctl_if;
  import i2s_pkg::*;

  logic                    en;
  logic                    audio_sdout;
  logic                    audio_mclk;
  logic                    audio_lrck;
  logic                    audio_sck;
  logic [SAMPLE_WIDTH-1:0] audio_left;
  logic [SAMPLE_WIDTH-1:0] audio_right;
  logic                    sample_valid;
  logic                    busy;

  modport master (
    input  en, audio_sdout,
    output audio_mclk, audio_lrck, audio_sck,
    output audio_left, audio_right, sample_valid, busy
  );

  modport slave (
    output en, audio_sdout,
    input  audio_mclk, audio_lrck, audio_sck,
    input  audio_left, audio_right, sample_valid, busy
  );

endinterface

// File: rtl/i2s_clkgen.sv
// Free-running 9-bit divider producing MCLK/SCK/LRCK and the per-bit capture
// and end-of-frame strobes; the counter is held at zero while not running.
module i2s_clkgen
  import i2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mclk,
  output logic              sck,
  output logic              lrck,
  output logic [SLOT_W-1:0] slot,
  output logic              capture,
  output logic              frame_done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Divided clocks come straight from flop outputs, so they are glitch-free.
  assign mclk       = cnt[MCLK_BIT];
  assign sck        = cnt[SCK_BIT];
  assign lrck       = cnt[LRCK_BIT];
  assign slot       = cnt[LRCK_BIT-1:SCK_BIT+1];
  assign capture    = run && (cnt[SCK_BIT:0] == CAPTURE_PHASE);
  assign frame_done = capture && (cnt == FRAME_DONE_CNT);

endmodule

// File: rtl/i2s_rx_ctl.sv
// I2S master receiver: drives the ADC clocks, deserialises 16-bit MSB-first
// left/right words and strobes sample_valid once per stereo frame.
module i2s_rx_ctl
  import i2s_pkg::*;
#(
  parameter int DISCARD_FRAMES = 2,   // frames dropped after enable, 0..15
  parameter int SAMPLE_W       = SAMPLE_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  i2s_rx_ctl_if.master bus
);

  state_e              state;
  logic [DISC_W-1:0]   disc_cnt;
  logic                sdout_q;
  logic [SAMPLE_W-1:0] left_shift;
  logic [SAMPLE_W-1:0] right_shift;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;
  logic                valid_q;

  logic              run;
  logic              lrck;
  logic [SLOT_W-1:0] slot;
  logic              capture;
  logic              frame_done;

  // Dropping en stops the divider on the same edge the FSM returns to IDLE.
  assign run = bus.en && (state != IDLE);

  i2s_clkgen u_clkgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mclk       (bus.audio_mclk),
    .sck        (bus.audio_sck),
    .lrck       (lrck),
    .slot       (slot),
    .capture    (capture),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      disc_cnt    <= '0;
      sdout_q     <= 1'b0;
      left_shift  <= '0;
      right_shift <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      sdout_q <= bus.audio_sdout;
      valid_q <= 1'b0;

      if (capture && in_data_slot(slot)) begin
        if (lrck) right_shift <= {right_shift[SAMPLE_W-2:0], sdout_q};
        else      left_shift  <= {left_shift[SAMPLE_W-2:0], sdout_q};
      end

      // Outputs load during settling too; only the strobe is withheld.
      if (frame_done) begin
        left_q  <= left_shift;
        right_q <= {right_shift[SAMPLE_W-2:0], sdout_q};
      end

      if (!bus.en) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            disc_cnt <= DISC_W'(DISCARD_FRAMES);
            state    <= (DISCARD_FRAMES == 0) ? RUN : SYNC;
          end
          SYNC: begin
            if (frame_done) begin
              if (disc_cnt <= DISC_W'(1)) begin
                disc_cnt <= '0;
                state    <= RUN;
              end else begin
                disc_cnt <= disc_cnt - DISC_W'(1);
              end
            end
          end
          RUN: begin
            if (frame_done) valid_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.audio_lrck   = lrck;
  assign bus.audio_left   = left_q;
  assign bus.audio_right  = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_i2s_rx_ctl.sv
// Directed bench for i2s_rx_ctl: two instances (no settling / two-frame
// settling) share one enable and one behavioural I2S ADC.
module tb_i2s_rx_ctl;
  import i2s_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic sdout = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_rx_ctl_if bus0 ();
  i2s_rx_ctl_if bus1 ();

  assign bus0.en          = en;
  assign bus1.en          = en;
  assign bus0.audio_sdout = sdout;
  assign bus1.audio_sdout = sdout;

  i2s_rx_ctl #(.DISCARD_FRAMES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master));
  i2s_rx_ctl #(.DISCARD_FRAMES(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.master));

  // ADC model: counts SCK falls since the last LRCK edge, drives the delay
  // bit in slot 0 and the word MSB-first from slot 1, zeros beyond its width.
  logic [23:0] adc_l = '0;
  logic [23:0] adc_r = '0;
  int          adc_w = 16;
  logic        delay_bit = 1'b0;
  int          slot = 0;
  logic        prev_sck = 1'b0;
  logic        prev_lrck = 1'b0;

  always @(negedge clk) begin : adc_model
    int          s;
    logic [23:0] w;
    s = slot;
    if (!en || !rst_n)                   s = 0;
    else if (bus0.audio_lrck != prev_lrck) s = 0;
    else if (prev_sck && !bus0.audio_sck)  s = s + 1;
    w = bus0.audio_lrck ? adc_r : adc_l;
    slot      <= s;
    prev_sck  <= bus0.audio_sck;
    prev_lrck <= bus0.audio_lrck;
    if (s == 0)           sdout <= delay_bit;
    else if (s <= adc_w)  sdout <= w[adc_w - s];
    else                  sdout <= 1'b0;
  end

  // Valid-strobe recorder: cycle index n counts clk edges from the en rise.
  int          q0[$];
  int          q1[$];
  logic [15:0] l0[$];
  logic [15:0] r0[$];
  logic [15:0] l1[$];
  logic [15:0] r1[$];
  logic [2:0]  clk_at_valid;

  task automatic enable_and_record(input int ncyc);
    q0.delete(); q1.delete(); l0.delete(); r0.delete(); l1.delete(); r1.delete();
    clk_at_valid = 3'bxxx;
    @(negedge clk);
    en = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus0.sample_valid) begin
        if (q0.size() == 0)
          clk_at_valid = {bus0.audio_lrck, bus0.audio_sck, bus0.audio_mclk};
        q0.push_back(n); l0.push_back(bus0.audio_left); r0.push_back(bus0.audio_right);
      end
      if (bus1.sample_valid) begin
        q1.push_back(n); l1.push_back(bus1.audio_left); r1.push_back(bus1.audio_right);
      end
    end
  endtask

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    int seen_high;
    seen_high = 0;
    en    = 1'b1;
    rst_n = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus0.audio_mclk || bus0.audio_sck || bus0.audio_lrck) seen_high++;
    end
    checks++;
    if (seen_high !== 0) begin
      errors++; $display("FAIL reset_clocks: high samples %0d, required 0", seen_high);
    end
    checks++;
    if ({bus0.audio_left, bus0.audio_right, bus0.sample_valid, bus0.busy} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got l=%h r=%h v=%b b=%b, required all 0",
                         bus0.audio_left, bus0.audio_right, bus0.sample_valid, bus0.busy);
    end
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus0.audio_mclk || bus0.audio_sck || bus0.audio_lrck || bus0.busy || bus1.busy)
        seen_high++;
    end
    checks++;
    if (seen_high !== 0) begin
      errors++; $display("FAIL idle_after_reset: high samples %0d, required 0", seen_high);
    end
  endtask

  task automatic test_basic();
    adc_l = 24'h00A5C3; adc_r = 24'h001234; adc_w = 16; delay_bit = 1'b0;
    enable_and_record(1000);
    checks++;
    if (q0.size() != 2) begin
      errors++; $display("FAIL basic_pulse_count: got %0d, required 2", q0.size());
    end else begin
      checks++;
      if (q0[0] != 392) begin
        errors++; $display("FAIL basic_latency: got %0d, required 392", q0[0]);
      end
      checks++;
      if (q0[1] != 904) begin
        errors++; $display("FAIL basic_period: got %0d, required 904", q0[1]);
      end
      checks++;
      if (l0[0] !== 16'hA5C3 || r0[0] !== 16'h1234) begin
        errors++; $display("FAIL basic_data: got %h/%h, required a5c3/1234", l0[0], r0[0]);
      end
      checks++;
      if (clk_at_valid !== 3'b111) begin
        errors++; $display("FAIL basic_clocks: lrck/sck/mclk got %b, required 111", clk_at_valid);
      end
    end
    checks++;
    if (q1.size() != 0) begin
      errors++; $display("FAIL basic_discard_dut1: got %0d pulses, required 0", q1.size());
    end
    checks++;
    if (bus1.audio_left !== 16'hA5C3 || bus1.audio_right !== 16'h1234) begin
      errors++; $display("FAIL sync_loads_outputs: got %h/%h, required a5c3/1234",
                         bus1.audio_left, bus1.audio_right);
    end
  endtask

  task automatic test_discard();
    int exp0[$];
    int exp1[$];
    exp0 = '{392, 904, 1416, 1928};
    exp1 = '{1416, 1928};
    restart();
    adc_l = 24'h007FFF; adc_r = 24'h008000; adc_w = 16; delay_bit = 1'b0;
    enable_and_record(2000);
    checks++;
    if (q0.size() != exp0.size()) begin
      errors++; $display("FAIL discard_dut0_count: got %0d, required %0d", q0.size(), exp0.size());
    end else begin
      foreach (exp0[i]) begin
        checks++;
        if (q0[i] != exp0[i]) begin
          errors++; $display("FAIL discard_dut0_time[%0d]: got %0d, required %0d", i, q0[i], exp0[i]);
        end
      end
    end
    checks++;
    if (q1.size() != exp1.size()) begin
      errors++; $display("FAIL discard_dut1_count: got %0d, required %0d", q1.size(), exp1.size());
    end else begin
      foreach (exp1[i]) begin
        checks++;
        if (q1[i] != exp1[i]) begin
          errors++; $display("FAIL discard_dut1_time[%0d]: got %0d, required %0d", i, q1[i], exp1[i]);
        end
      end
      checks++;
      if (l1[0] !== 16'h7FFF || r1[0] !== 16'h8000) begin
        errors++; $display("FAIL discard_data: got %h/%h, required 7fff/8000", l1[0], r1[0]);
      end
    end
  endtask

  task automatic test_truncation();
    restart();
    adc_l = 24'h8000FF; adc_r = 24'hFFFF01; adc_w = 24; delay_bit = 1'b1;
    enable_and_record(400);
    checks++;
    if (q0.size() != 1) begin
      errors++; $display("FAIL trunc_pulse_count: got %0d, required 1", q0.size());
    end else begin
      checks++;
      if (l0[0] !== 16'h8000 || r0[0] !== 16'hFFFF) begin
        errors++; $display("FAIL trunc_data: got %h/%h, required 8000/ffff", l0[0], r0[0]);
      end
    end
  endtask

  // Entered right after test_truncation: dut0 is in RUN with cnt == 399.
  task automatic test_abort();
    int pulses;
    adc_l = 24'h001111; adc_r = 24'h002222; adc_w = 16; delay_bit = 1'b0;
    repeat (449) @(negedge clk);   // cnt reaches 0x150 of the next frame
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus0.audio_lrck, bus0.audio_sck, bus0.audio_mclk, bus0.busy, bus1.busy} !== 5'd0) begin
      errors++; $display("FAIL abort_idle: lrck/sck/mclk/busy0/busy1 got %b, required 00000",
                         {bus0.audio_lrck, bus0.audio_sck, bus0.audio_mclk, bus0.busy, bus1.busy});
    end
    pulses = 0;
    repeat (600) begin
      @(negedge clk);
      if (bus0.sample_valid || bus1.sample_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL abort_no_valid: got %0d pulses, required 0", pulses);
    end
    checks++;
    if (bus0.audio_left !== 16'h8000 || bus0.audio_right !== 16'hFFFF) begin
      errors++; $display("FAIL abort_hold: got %h/%h, required 8000/ffff",
                         bus0.audio_left, bus0.audio_right);
    end
    enable_and_record(1500);
    checks++;
    if (q0.size() != 3 || q0[0] != 392) begin
      errors++; $display("FAIL reenable_dut0: got %0d pulses first %0d, required 3 first 392",
                         q0.size(), (q0.size() > 0) ? q0[0] : -1);
    end
    checks++;
    if (q1.size() != 1 || q1[0] != 1416) begin
      errors++; $display("FAIL reenable_dut1: got %0d pulses first %0d, required 1 first 1416",
                         q1.size(), (q1.size() > 0) ? q1[0] : -1);
    end else begin
      checks++;
      if (l1[0] !== 16'h1111 || r1[0] !== 16'h2222) begin
        errors++; $display("FAIL reenable_data: got %h/%h, required 1111/2222", l1[0], r1[0]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus0.audio_left, bus0.audio_right, bus0.sample_valid, bus0.busy,
         bus0.audio_lrck, bus0.audio_sck, bus0.audio_mclk, bus1.busy} !== 38'd0) begin
      errors++; $display("FAIL async_reset: got l=%h r=%h v=%b b=%b clks=%b, required all 0",
                         bus0.audio_left, bus0.audio_right, bus0.sample_valid, bus0.busy,
                         {bus0.audio_lrck, bus0.audio_sck, bus0.audio_mclk});
    end
    #2 rst_n = 1'b1;
    checks++;
    if (bus0.busy !== 1'b0) begin
      errors++; $display("FAIL async_reset_state: busy got %b, required 0", bus0.busy);
    end
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_discard();
    test_truncation();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
